// File: rtl/pat_scan_unit.sv
// Pattern-count engine: reads a 5-bit pattern and a 32-byte message from data memory,
// counts 5-bit window matches, and writes three result bytes back to memory.
module pat_scan_unit #(
  parameter int STR_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(STR_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_WR0, S_WR1, S_WR2, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] cap_idx;
  logic          cap_vld;
  logic [4:0]    pat;
  logic [7:0]    prev;
  logic [7:0]    ctb, cto, cts;
  logic          accept;
  logic [2:0]    m_in, m_cross;
  logic [15:0]   pair;

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_READ;
      S_READ:  if (rd_idx == IW'(STR_BYTES)) state_n = S_DRAIN;
      S_DRAIN: state_n = S_WR0;
      S_WR0:   state_n = S_WR1;
      S_WR1:   state_n = S_WR2;
      S_WR2:   state_n = S_DONE;
      S_DONE:  if (start) state_n = S_READ;
      default: state_n = S_IDLE;
    endcase
  end

  // Windows inside the byte sit at pair[4+i:i]; windows straddling prev/byte at pair[8+i:4+i].
  always_comb begin
    pair    = {prev, mem_rdata};
    m_in    = '0;
    m_cross = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pair[i +: 5] == pat)       m_in    = m_in + 3'd1;
      if (pair[(i + 4) +: 5] == pat) m_cross = m_cross + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      rd_idx  <= '0;
      cap_idx <= '0;
      cap_vld <= 1'b0;
      pat     <= '0;
      prev    <= '0;
      ctb     <= '0;
      cto     <= '0;
      cts     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rd_idx  <= '0;
        cap_idx <= '0;
        cap_vld <= 1'b0;
        prev    <= '0;
        ctb     <= '0;
        cto     <= '0;
        cts     <= '0;
      end else begin
        cap_vld <= (state == S_READ);
        cap_idx <= rd_idx;
        if (state == S_READ) rd_idx <= rd_idx + IW'(1);
        // cap_idx 0 returns the pattern byte; cap_idx k returns message byte k-1
        if (cap_vld) begin
          if (cap_idx == '0) begin
            pat <= mem_rdata[7:3];
          end else begin
            ctb  <= ctb + 8'(m_in);
            cto  <= cto + 8'(m_in != '0);
            cts  <= cts + 8'(m_in) + ((cap_idx > IW'(1)) ? 8'(m_cross) : 8'd0);
            prev <= mem_rdata;
          end
        end
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_READ: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        mem_addr  = (rd_idx == '0) ? AW'(PAT_ADDR) : (AW'(rd_idx) - AW'(1));
      end
      S_DRAIN: busy = 1'b1;
      S_WR0: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = AW'(RES_ADDR);     mem_wdata = ctb;
      end
      S_WR1: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = AW'(RES_ADDR + 1); mem_wdata = cto;
      end
      S_WR2: begin
        busy = 1'b1; mem_wr_en = 1'b1; mem_addr = AW'(RES_ADDR + 2); mem_wdata = cts;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
